// File: rtl/axi_init_sequencer.sv
// Command-driven fill engine: sequences one single-beat write per word through a
// start/done writer handshake and reports OK / ABORTED / TIMEOUT with a word count.
module axi_init_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int TIMEOUT    = 1024,
   parameter int ADDR_STEP  = DATA_WIDTH / 8
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   input  logic [1:0]            cmd_mode,
   input  logic [DATA_WIDTH-1:0] cmd_seed,
   input  logic                  abort,
   output logic                  wr_start,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_done,
   output logic                  busy,
   output logic                  cmd_done,
   output logic [1:0]            cmd_status,
   output logic [CNT_WIDTH-1:0]  words_written
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

   localparam logic [1:0] MODE_CONST = 2'b00;
   localparam logic [1:0] MODE_INCR  = 2'b01;
   localparam logic [1:0] MODE_ADDR  = 2'b10;
   localparam logic [1:0] MODE_LFSR  = 2'b11;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORTED = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   localparam int              WAIT_W    = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t                state, state_next;
   logic [1:0]            mode;
   logic [CNT_WIDTH-1:0]  remaining;
   logic [WAIT_W-1:0]     wait_cnt;
   logic                  abort_pending;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [DATA_WIDTH-1:0] next_data;
   logic [DATA_WIDTH-1:0] first_data;
   logic [31:0]           lfsr_cur;
   logic [31:0]           lfsr_next;
   logic                  timed_out;
   logic                  last_word;
   logic                  stop_req;

   assign timed_out = (wait_cnt == WAIT_LAST);
   assign last_word = (remaining == CNT_WIDTH'(1));
   assign stop_req  = abort | abort_pending;
   assign next_addr = wr_addr + ADDR_WIDTH'(ADDR_STEP);
   assign lfsr_cur  = 32'(wr_data);
   assign lfsr_next = {lfsr_cur[30:0], lfsr_cur[31] ^ lfsr_cur[21] ^ lfsr_cur[1] ^ lfsr_cur[0]};

   // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      first_data = cmd_seed;
      case (cmd_mode)
         MODE_ADDR: first_data = DATA_WIDTH'(cmd_base);
         MODE_LFSR: first_data = (cmd_seed == '0) ? DATA_WIDTH'(1) : cmd_seed;
         default:   first_data = cmd_seed;
      endcase
   end

   always_comb begin
      next_data = wr_data;
      case (mode)
         MODE_CONST: next_data = wr_data;
         MODE_INCR:  next_data = wr_data + DATA_WIDTH'(1);
         MODE_ADDR:  next_data = DATA_WIDTH'(next_addr);
         MODE_LFSR:  next_data = DATA_WIDTH'(lfsr_next);
         default:    next_data = wr_data;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (cmd_valid) state_next = (cmd_count == '0) ? S_FINISH : S_ISSUE;
         S_ISSUE:  state_next = S_WAIT;
         S_WAIT: begin
            // A returning word takes priority over the timeout firing in the same cycle.
            if (wr_done)        state_next = (stop_req || last_word) ? S_FINISH : S_ISSUE;
            else if (timed_out) state_next = S_FINISH;
         end
         S_FINISH: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == S_IDLE);
      busy      = (state != S_IDLE);
      wr_start  = (state == S_ISSUE);
      cmd_done  = (state == S_FINISH);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         mode          <= MODE_CONST;
         remaining     <= '0;
         wait_cnt      <= '0;
         abort_pending <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         cmd_status    <= ST_OK;
         words_written <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  mode          <= cmd_mode;
                  remaining     <= cmd_count;
                  words_written <= '0;
                  cmd_status    <= ST_OK;
                  if (cmd_count != '0) begin
                     wr_addr <= cmd_base;
                     wr_data <= first_data;
                  end
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               if (abort) abort_pending <= 1'b1;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
               if (abort) abort_pending <= 1'b1;
               if (wr_done) begin
                  words_written <= words_written + CNT_WIDTH'(1);
                  remaining     <= remaining - CNT_WIDTH'(1);
                  if (stop_req) begin
                     cmd_status <= ST_ABORTED;
                  end else if (!last_word) begin
                     wr_addr <= next_addr;
                     wr_data <= next_data;
                  end
               end else if (timed_out) begin
                  cmd_status <= ST_TIMEOUT;
               end
            end
            S_FINISH: abort_pending <= 1'b0;
            default:  abort_pending <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_init_sequencer.sv
// Scoreboard bench: the driver pushes expected writes/completions computed from the
// command rules; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_init_sequencer;

   localparam int TO   = 16;
   localparam int STEP = 4;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_base;
   logic [15:0] cmd_count;
   logic [1:0]  cmd_mode;
   logic [31:0] cmd_seed;
   logic        abort;
   logic        wr_start;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_done;
   logic        busy;
   logic        cmd_done;
   logic [1:0]  cmd_status;
   logic [15:0] words_written;

   axi_init_sequencer #(.TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_mode(cmd_mode), .cmd_seed(cmd_seed),
      .abort(abort),
      .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
      .busy(busy), .cmd_done(cmd_done), .cmd_status(cmd_status), .words_written(words_written)
   );

   always #5 ACLK = ~ACLK;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { logic [1:0] status; int words; bit tmo; } done_t;

   wr_t   exp_wq[$];
   done_t exp_dq[$];

   int vectors = 0;
   int miscompares = 0;

   // Writer configuration, written by the driver only.
   int lat[64];
   int hang_idx = 0;
   int abort_idx = 0;
   int abort_off = 0;
   int idle_abort_req = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] d);
      return {d[30:0], d[31] ^ d[21] ^ d[1] ^ d[0]};
   endfunction

   // Writer model: done L cycles after each start, optional hang and abort injection.
   initial begin
      int done_timer = 0;
      int abort_timer = 0;
      int start_idx = 0;
      int idle_abort_seen = 0;
      wr_done = 1'b0;
      abort   = 1'b0;
      forever begin
         @(posedge ACLK); #1;
         wr_done = 1'b0;
         abort   = 1'b0;
         if (ARESETN !== 1'b1) begin
            done_timer = 0; abort_timer = 0; start_idx = 0;
            continue;
         end
         if (idle_abort_req != idle_abort_seen) begin
            abort = 1'b1;
            idle_abort_seen = idle_abort_req;
         end
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) wr_done = 1'b1;
         end
         if (abort_timer > 0) begin
            abort_timer--;
            if (abort_timer == 0) abort = 1'b1;
         end
         if (wr_start === 1'b1) begin
            start_idx++;
            if (start_idx != hang_idx) done_timer = lat[(start_idx - 1) % 64];
            if (start_idx == abort_idx) begin
               if (abort_off == 0) abort = 1'b1;
               else                abort_timer = 1;
            end
         end
         if (cmd_done === 1'b1) start_idx = 0;
      end
   end

   // Monitor: compares every presented write/completion, and reset values.
   initial begin
      int cyc = 0;
      int trig = -100;
      int last_start = -100;
      int exp_cyc;
      bit rst_prev = 0;
      wr_t w;
      done_t e;
      forever begin
         @(negedge ACLK);
         cyc++;
         if (ARESETN !== 1'b1) begin
            if (rst_prev) begin
               check("rst_wr_start", 64'(wr_start), 64'(0));
               check("rst_cmd_done", 64'(cmd_done), 64'(0));
               check("rst_busy", 64'(busy), 64'(0));
               check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
               check("rst_wr_addr", 64'(wr_addr), 64'(0));
               check("rst_wr_data", 64'(wr_data), 64'(0));
               check("rst_status", 64'(cmd_status), 64'(0));
               check("rst_words", 64'(words_written), 64'(0));
            end
            rst_prev = 1;
            trig = -100;
            continue;
         end
         rst_prev = 0;
         if (wr_start === 1'b1) begin
            if (exp_wq.size() == 0) begin
               check("unexpected_wr_start", 64'(1), 64'(0));
            end else begin
               w = exp_wq.pop_front();
               check("wr_addr", 64'(wr_addr), 64'(w.addr));
               check("wr_data", 64'(wr_data), 64'(w.data));
               check("start_latency", 64'(cyc - trig), 64'(1));
            end
            last_start = cyc;
         end
         if (cmd_done === 1'b1) begin
            if (exp_dq.size() == 0) begin
               check("unexpected_cmd_done", 64'(1), 64'(0));
            end else begin
               e = exp_dq.pop_front();
               exp_cyc = e.tmo ? last_start + TO + 1 : trig + 1;
               check("done_cycle", 64'(cyc), 64'(exp_cyc));
               check("cmd_status", 64'(cmd_status), 64'(e.status));
               check("words_written", 64'(words_written), 64'(e.words));
            end
         end
         if (cmd_valid === 1'b1 && cmd_ready === 1'b1) trig = cyc;
         if (wr_done === 1'b1 && busy === 1'b1 && wr_start !== 1'b1 && cmd_done !== 1'b1) trig = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic int pick_lat();
      return ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, 6));
   endfunction

   // kind: 0 normal, 1 abort during word k, 2 writer hangs on word k.
   task automatic run_cmd(input logic [31:0] base, input int count, input logic [1:0] mode,
                          input logic [31:0] seed, input int kind, input int k, input int fix_lat);
      int    n_issue;
      int    n;
      logic  [31:0] a;
      logic  [31:0] d;
      done_t e;
      for (int i = 0; i < 64; i++) lat[i] = (fix_lat != 0) ? fix_lat : pick_lat();
      hang_idx  = (kind == 2) ? k : 0;
      abort_idx = (kind == 1) ? k : 0;
      abort_off = int'($urandom_range(0, 1));
      n_issue   = (kind == 0) ? count : k;
      d = (mode == 2'b11 && seed == 32'h0) ? 32'h1 : seed;
      for (int i = 0; i < n_issue; i++) begin
         a = base + 32'(i * STEP);
         case (mode)
            2'b00: exp_wq.push_back('{a, seed});
            2'b01: exp_wq.push_back('{a, seed + 32'(i)});
            2'b10: exp_wq.push_back('{a, a});
            default: begin
               exp_wq.push_back('{a, d});
               d = lfsr_step(d);
            end
         endcase
      end
      e.status = 2'(kind);
      e.words  = (kind == 2) ? k - 1 : n_issue;
      e.tmo    = (kind == 2);
      exp_dq.push_back(e);
      @(posedge ACLK); #1;
      cmd_valid = 1'b1;
      cmd_base  = base;
      cmd_count = 16'(count);
      cmd_mode  = mode;
      cmd_seed  = seed;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      for (n = 0; n < 2000 && cmd_ready !== 1'b1; n++) begin
         @(posedge ACLK); #1;
      end
      check("cmd_complete", 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      int cnt;
      int kind;
      int k;
      logic [31:0] base;
      ARESETN   = 1'b0;
      cmd_valid = 1'b0;
      cmd_base  = '0;
      cmd_count = '0;
      cmd_mode  = '0;
      cmd_seed  = '0;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      @(posedge ACLK); #1;

      run_cmd(32'h0000_1000, 4, 2'b00, 32'hA5A5_A5A5, 0, 0, 3);
      run_cmd(32'h0000_2000, 3, 2'b01, 32'hFFFF_FFFE, 0, 0, 3);
      run_cmd(32'hFFFF_FFF8, 3, 2'b10, 32'h1234_5678, 0, 0, 3);
      run_cmd(32'h0000_3000, 3, 2'b11, 32'h0000_0001, 0, 0, 3);
      run_cmd(32'h0000_3100, 3, 2'b11, 32'h0000_0000, 0, 0, 3);
      run_cmd(32'h0000_4000, 0, 2'b00, 32'hDEAD_BEEF, 0, 0, 3);

      // Abort while idle must leave the next command untouched.
      idle_abort_req = idle_abort_req + 1;
      repeat (3) @(posedge ACLK);
      #1;
      run_cmd(32'h0000_5000, 2, 2'b00, 32'h0F0F_0F0F, 0, 0, 3);
      run_cmd(32'h0000_6000, 8, 2'b01, 32'h0000_0010, 1, 2, 3);
      run_cmd(32'h0000_7000, 5, 2'b10, 32'h0, 2, 1, 3);
      run_cmd(32'h0000_8000, 3, 2'b01, 32'h0000_0100, 0, 0, TO);
      run_cmd(32'h0000_9000, 4, 2'b00, 32'h5555_AAAA, 2, 3, 2);

      // Reset in the WAIT of the first word: one start seen, never a cmd_done.
      for (int i = 0; i < 64; i++) lat[i] = 5;
      hang_idx  = 0;
      abort_idx = 0;
      exp_wq.push_back('{32'h0000_A000, 32'h0000_1234});
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_base = 32'h0000_A000; cmd_count = 16'd8;
      cmd_mode  = 2'b00; cmd_seed = 32'h0000_1234;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b0;
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;

      for (int t = 0; t < 40; t++) begin
         cnt  = int'($urandom_range(0, 12));
         kind = int'($urandom_range(0, 5));
         kind = (cnt == 0 || kind > 1) ? 0 : kind + 1;
         k    = (cnt == 0) ? 0 : int'($urandom_range(1, cnt));
         base = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 : $urandom;
         run_cmd(base, cnt, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom, kind, k, 0);
      end

      repeat (5) @(posedge ACLK);
      #1;
      check("writes_left", 64'(exp_wq.size()), 64'(0));
      check("dones_left", 64'(exp_dq.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
